bit_collector: RTL and testbench

BIT_COLLECTOR -- requirements
Module: bit_collector

---
 rtl/bit_collector_if.sv | 35 +++
 rtl/bit_collector.sv | 134 +++++++++++++
 tb/tb_bit_collector.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_collector_if.sv
// bit_collector_if: serial-bit input strobes and downstream FIFO push bus
// for bit_collector.
//   data_in       serial data bit (asynchronous)
//   write_in      bit strobe (asynchronous level)
//   enqueue_in    word-commit strobe (asynchronous level)
//   fifo_full     downstream FIFO cannot accept a push this cycle
//   push_out      one-cycle push pulse to the FIFO
//   push_data     assembled word, zero unless push_out=1
//   ready_out     collector idle and able to take a new word
//   bit_count_out bits collected in the current word
//   error_out     sticky protocol-error flag
// The slave modport is the collector side; master is the producer/FIFO side.
interface bit_collector_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             write_in;
  logic             enqueue_in;
  logic             fifo_full;
  logic             push_out;
  logic [WIDTH-1:0] push_data;
  logic             ready_out;
  logic [3:0]       bit_count_out;
  logic             error_out;

  modport slave (
    input  data_in, write_in, enqueue_in, fifo_full,
    output push_out, push_data, ready_out, bit_count_out, error_out
  );

  modport master (
    output data_in, write_in, enqueue_in, fifo_full,
    input  push_out, push_data, ready_out, bit_count_out, error_out
  );
endinterface

// File: rtl/bit_collector.sv
// bit_collector: assembles WIDTH serial bits (LSB first) strobed by an
// asynchronous write_in level into a word, and pushes the word to a
// downstream FIFO when an asynchronous enqueue_in level rises.
// Ports:
//   clock_1MHz  sole clock, rising edge
//   rst         synchronous active-low reset
//   bus         bit_collector_if.slave (strobes in, FIFO push/status out)
// Parameters: SYNC_STAGES synchronizer depth, WIDTH bits per word (<= 15).
module bit_collector #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic           clock_1MHz,
  input  logic           rst,
  bit_collector_if.slave bus
);
  localparam logic [3:0] FULL_CNT = 4'(WIDTH);

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    WAIT_SPACE = 2'd1,
    PUSH       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_data_sync, r_wr_sync, r_enq_sync, r_sync_vld;
  logic                   w_data_s, w_wr_s, w_enq_s, w_sync_ok;
  logic                   r_wr_prev, r_enq_prev;
  logic                   r_wr_arm, r_enq_arm;
  logic                   r_wr_evt, r_enq_evt, r_wr_bit;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_count, w_count_nxt;
  logic [WIDTH-1:0]       r_shift, w_shift_nxt;
  logic                   r_err, w_err_nxt;

  assign w_data_s  = r_data_sync[SYNC_STAGES-1];
  assign w_wr_s    = r_wr_sync[SYNC_STAGES-1];
  assign w_enq_s   = r_enq_sync[SYNC_STAGES-1];
  // High once the synchronizer outputs reflect inputs sampled after reset.
  assign w_sync_ok = r_sync_vld[SYNC_STAGES-1];

  // Synchronizers and registered edge detectors. A strobe only becomes
  // "armed" after it has been observed low post-reset, so a level held high
  // through reset release cannot masquerade as a fresh rising edge.
  always_ff @(posedge clock_1MHz) begin
    if (!rst) begin
      r_data_sync <= '0;
      r_wr_sync   <= '0;
      r_enq_sync  <= '0;
      r_sync_vld  <= '0;
      r_wr_prev   <= 1'b0;
      r_enq_prev  <= 1'b0;
      r_wr_arm    <= 1'b0;
      r_enq_arm   <= 1'b0;
      r_wr_evt    <= 1'b0;
      r_enq_evt   <= 1'b0;
      r_wr_bit    <= 1'b0;
    end else begin
      r_data_sync <= SYNC_STAGES'({r_data_sync, bus.data_in});
      r_wr_sync   <= SYNC_STAGES'({r_wr_sync, bus.write_in});
      r_enq_sync  <= SYNC_STAGES'({r_enq_sync, bus.enqueue_in});
      r_sync_vld  <= SYNC_STAGES'({r_sync_vld, 1'b1});
      r_wr_prev   <= w_wr_s;
      r_enq_prev  <= w_enq_s;
      r_wr_arm    <= r_wr_arm  | (w_sync_ok & ~w_wr_s);
      r_enq_arm   <= r_enq_arm | (w_sync_ok & ~w_enq_s);
      r_wr_evt    <= w_wr_s  & ~r_wr_prev  & r_wr_arm;
      r_enq_evt   <= w_enq_s & ~r_enq_prev & r_enq_arm;
      // Data bit captured alongside the write event it belongs to.
      r_wr_bit    <= w_data_s;
    end
  end

  // ---- stage boundary: events -> FSM / word assembly ----
  always_ff @(posedge clock_1MHz) begin
    if (!rst) begin
      r_state <= COLLECT;
      r_count <= 4'd0;
      r_shift <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_err_nxt   = r_err;
    unique case (r_state)
      COLLECT: begin
        // Enqueue wins over a simultaneous write; the write is dropped.
        if (r_enq_evt) begin
          if (r_count == FULL_CNT) begin
            w_state_nxt = bus.fifo_full ? WAIT_SPACE : PUSH;
          end else begin
            w_count_nxt = 4'd0;
            w_shift_nxt = '0;
            w_err_nxt   = 1'b1;
          end
        end else if (r_wr_evt) begin
          if (r_count == FULL_CNT) begin
            w_err_nxt = 1'b1;
          end else begin
            // Register is cleared between words, so OR-ing places the bit.
            w_shift_nxt = r_shift | (WIDTH'(r_wr_bit) << r_count);
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
      WAIT_SPACE: begin
        if (r_wr_evt) w_err_nxt = 1'b1;
        if (!bus.fifo_full) w_state_nxt = PUSH;
      end
      PUSH: begin
        if (r_wr_evt) w_err_nxt = 1'b1;
        w_count_nxt = 4'd0;
        w_shift_nxt = '0;
        w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  assign bus.push_out      = (r_state == PUSH);
  assign bus.push_data     = (r_state == PUSH) ? r_shift : '0;
  assign bus.ready_out     = (r_state == COLLECT) && (r_count == 4'd0) && !bus.fifo_full;
  assign bus.bit_count_out = r_count;
  assign bus.error_out     = r_err;
endmodule

// File: tb/tb_bit_collector.sv
`timescale 1ns/1ps
module tb_bit_collector;
  localparam int SS = 2;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_collector_if #(.WIDTH(W)) bus ();

  bit_collector #(.SYNC_STAGES(SS), .WIDTH(W)) dut (
    .clock_1MHz (clk),
    .rst        (rst),
    .bus        (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      name;
    logic [7:0] word;
    int         nbits;
    int         full_cyc;
    bit         exp_push;
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard: every cycle either a push matches the head of the queue
  // (data and cycle), or push_data must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.push_out) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push: got push of %0h at cycle %0d, expected none", bus.push_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("push_data", 32'(bus.push_data), 32'(e.data));
          check("push_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("idle_push_data", 32'(bus.push_data), 32'd0);
      end
    end
  end

  initial begin
    #(60_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.data_in = 1'b0;
    bus.write_in = 1'b0;
    bus.enqueue_in = 1'b0;
    bus.fifo_full = 1'b0;
    step(2);
    rst = 1'b1;
    step(5);
  endtask

  task automatic send_bit(input logic b);
    bus.data_in = b;
    step(1);
    bus.write_in = 1'b1;
    step(3);
    bus.write_in = 1'b0;
    step(3);
  endtask

  task automatic pulse_enq();
    bus.enqueue_in = 1'b1;
    step(4);
    bus.enqueue_in = 1'b0;
    step(4);
  endtask

  initial begin
    int nb;
    logic [7:0] w;
    vecs[0] = '{"w80",     8'h80, 8, 0,  1'b1, 8'h80, 1'b0};
    vecs[1] = '{"w81full", 8'h81, 8, 50, 1'b1, 8'h81, 1'b0};
    vecs[2] = '{"part5",   8'h15, 5, 0,  1'b0, 8'h00, 1'b1};
    vecs[3] = '{"over9",   8'hFF, 9, 0,  1'b1, 8'hFF, 1'b1};
    vecs[4] = '{"w3C",     8'h3C, 8, 0,  1'b1, 8'h3C, 1'b0};
    vecs[5] = '{"part0",   8'h00, 0, 0,  1'b0, 8'h00, 1'b1};
    vecs[6] = '{"wA5full", 8'hA5, 8, 3,  1'b1, 8'hA5, 1'b0};

    do_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      check({vecs[i].name, "_rst_count"}, 32'(bus.bit_count_out), 32'd0);
      check({vecs[i].name, "_rst_err"},   32'(bus.error_out), 32'd0);
      check({vecs[i].name, "_rst_ready"}, 32'(bus.ready_out), 32'd1);
      for (int b = 0; b < vecs[i].nbits; b++)
        send_bit(b < 8 ? vecs[i].word[b] : 1'b1);
      nb = (vecs[i].nbits > W) ? W : vecs[i].nbits;
      check({vecs[i].name, "_count"}, 32'(bus.bit_count_out), 32'(nb));
      if (vecs[i].full_cyc > 0) begin
        bus.fifo_full = 1'b1;
        step(1);
        pulse_enq();
        step(vecs[i].full_cyc);
        check({vecs[i].name, "_wait_ready"}, 32'(bus.ready_out), 32'd0);
        check({vecs[i].name, "_wait_count"}, 32'(bus.bit_count_out), 32'd8);
        sb.push_back('{vecs[i].exp_data, cyc + 1});
        bus.fifo_full = 1'b0;
        step(6);
      end else begin
        if (vecs[i].exp_push) sb.push_back('{vecs[i].exp_data, cyc + SS + 2});
        pulse_enq();
        step(4);
      end
      check({vecs[i].name, "_missing_push"}, 32'(sb.size()), 32'd0);
      sb.delete();
      check({vecs[i].name, "_end_count"}, 32'(bus.bit_count_out), 32'd0);
      check({vecs[i].name, "_end_err"},   32'(bus.error_out), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_end_ready"}, 32'(bus.ready_out), 32'd1);
    end

    // Reset mid-word drops the partial word; the next word is clean.
    do_reset();
    for (int b = 0; b < 4; b++) send_bit(1'b1);
    check("mid_count4", 32'(bus.bit_count_out), 32'd4);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check("mid_rst_count", 32'(bus.bit_count_out), 32'd0);
    step(1);
    check("mid_rst_ready", 32'(bus.ready_out), 32'd1);
    step(4);
    w = 8'h82;
    for (int b = 0; b < 8; b++) send_bit(w[b]);
    sb.push_back('{8'h82, cyc + SS + 2});
    pulse_enq();
    step(4);
    check("mid_82_pushed", 32'(sb.size()), 32'd0);
    check("mid_82_err", 32'(bus.error_out), 32'd0);
    sb.delete();

    // Reset while waiting for FIFO space drops the word without a push.
    do_reset();
    w = 8'h11;
    for (int b = 0; b < 8; b++) send_bit(w[b]);
    bus.fifo_full = 1'b1;
    pulse_enq();
    step(3);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    step(10);
    check("ws_rst_count", 32'(bus.bit_count_out), 32'd0);
    check("ws_rst_ready", 32'(bus.ready_out), 32'd1);

    // Strobe held high across reset release produces no event until re-raised.
    bus.write_in = 1'b1;
    bus.data_in = 1'b1;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(10);
    check("held_no_event", 32'(bus.bit_count_out), 32'd0);
    bus.write_in = 1'b0;
    step(4);
    bus.write_in = 1'b1;
    step(4);
    bus.write_in = 1'b0;
    step(3);
    check("held_rearm", 32'(bus.bit_count_out), 32'd1);

    // Simultaneous write and enqueue with a full word: enqueue only.
    do_reset();
    w = 8'h5A;
    for (int b = 0; b < 8; b++) send_bit(w[b]);
    bus.data_in = 1'b1;
    step(1);
    sb.push_back('{8'h5A, cyc + SS + 2});
    bus.write_in = 1'b1;
    bus.enqueue_in = 1'b1;
    step(4);
    bus.write_in = 1'b0;
    bus.enqueue_in = 1'b0;
    step(6);
    check("same_edge_pushed", 32'(sb.size()), 32'd0);
    check("same_edge_count", 32'(bus.bit_count_out), 32'd0);
    check("same_edge_err", 32'(bus.error_out), 32'd0);

    step(2);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
